// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flip-flop driver.
package sr_pkg;

    // Controller states; the ST_ prefix keeps the names clear of the SETTLE parameter.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } sr_state_e;

    // Ceiling for the mismatch counter.
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // Largest settle time the driver is designed for.
    localparam int SETTLE_MAX = 7;

    // Saturating increment for the mismatch counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the drive and settle phases.
// expire is high during the final counted cycle so the controller can
// change phase on the edge that ends it.
module sr_pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == W'(1));

endmodule

// File: rtl/sr_driver.sv
// Command-driven controller for an external SR flip-flop: pulses S or R,
// waits for the flop to settle, checks the fed-back Q and reports.
// SETTLE is expected to lie in 1..7.
module sr_driver
    import sr_pkg::*;
#(
    parameter int LEN_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_target,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             S,
    output logic             R,
    input  logic             q_fb,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    // Timer wide enough for both the pulse length and the settle time.
    localparam int TW = (LEN_W > 3) ? LEN_W : 3;
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE);

    sr_state_e   state_q, state_d;
    logic        target_q, target_d;
    logic        s_q, s_d;
    logic        r_q, r_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        ready_q, ready_d;

    logic          handshake;
    logic          mismatch;
    logic [TW-1:0] len_eff;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expire;

    assign handshake = cmd_valid && ready_q;

    // A zero length still produces a one-cycle pulse.
    always_comb begin
        len_eff = TW'(cmd_len);
        if (cmd_len == '0) begin
            len_eff = TW'(1);
        end
    end

    sr_pulse_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        ready_d   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        mismatch  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (handshake) begin
                    target_d = cmd_target;
                    ready_d  = 1'b0;
                    if (q_fb == cmd_target) begin
                        // Flop already holds the requested value: report at once.
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_DRIVE;
                        s_d      = cmd_target;
                        r_d      = ~cmd_target;
                        tmr_load = 1'b1;
                        tmr_val  = len_eff;
                    end
                end
            end

            ST_DRIVE: begin
                if (tmr_expire) begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end else begin
                    s_d = target_q;
                    r_d = ~target_q;
                end
            end

            ST_SETTLE: begin
                if (tmr_expire) begin
                    // Last settle cycle: this is where feedback is judged.
                    mismatch = (q_fb != target_q);
                    state_d  = ST_RESP;
                    done_d   = 1'b1;
                    err_d    = mismatch;
                    if (mismatch) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Controller state and registered outputs; reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            target_q  <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign S         = s_q;
    assign R         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule
